// File: rtl/rcon_pkg.sv
// Shared types and helpers for the round-constant table.
//   rcon_state_e    : controller states (idle, self-fill, streaming)
//   RconDefaultPoly : default reduction polynomial low bits (AES, x^8+x^4+x^3+x+1)
//   RconDefaultSeed : default first table entry
//   xtime()         : GF(2^n) doubling for widths up to RconMaxW bits
package rcon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StStream
    } rcon_state_e;

    localparam logic [7:0] RconDefaultPoly = 8'h1B;
    localparam logic [7:0] RconDefaultSeed = 8'h01;
    localparam int unsigned RconMaxW = 32;

    // Shift left inside a width-bit field; fold the carry-out back in with poly.
    function automatic logic [RconMaxW-1:0] xtime(input logic [RconMaxW-1:0] v,
                                                  input logic [RconMaxW-1:0] poly,
                                                  input int unsigned         width);
        logic [RconMaxW-1:0] mask;
        logic [RconMaxW-1:0] res;
        logic                carry;
        mask  = (width >= RconMaxW) ? '1 : ((RconMaxW'(1) << width) - RconMaxW'(1));
        carry = |((v >> (width - 1)) & RconMaxW'(1));
        res   = (v << 1) & mask;
        if (carry) begin
            res = res ^ (poly & mask);
        end
        return res;
    endfunction

endpackage

// File: rtl/rcon_xtime.sv
// Combinational GF(2^DATA_W) doubling stage used by the self-fill sequence.
//   v_i : current constant
//   v_o : xtime(v_i) reduced by POLY
module rcon_xtime
    import rcon_pkg::*;
#(
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(RconDefaultPoly)
) (
    input  logic [DATA_W-1:0] v_i,
    output logic [DATA_W-1:0] v_o
);

    assign v_o = DATA_W'(xtime(RconMaxW'(v_i), RconMaxW'(POLY), DATA_W));

endmodule

// File: rtl/rcon_table_gen.sv
// Round-constant table for the key-expansion path.
// Host side : registered read (out_o/out_valid_o, 1-cycle latency), write in idle only.
// Init side : init_start_i fills entries 0..DEPTH-1 with SEED, xtime(SEED), ...;
//             init_busy_o while filling, init_done_o sticky afterwards.
// Stream    : stream_start_i (needs init_done_o) emits entries 0..DEPTH-1 over a
//             valid/ready port with index and last flag.
// Reset rst_i is synchronous, active-high; table contents are not reset.
module rcon_table_gen
    import rcon_pkg::*;
#(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 10,
    parameter int unsigned       ADDR_W = 4,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(RconDefaultPoly),
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(RconDefaultSeed)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] out_o,
    output logic              out_valid_o,
    input  logic              init_start_i,
    output logic              init_busy_o,
    output logic              init_done_o,
    input  logic              stream_start_i,
    output logic              stream_valid_o,
    input  logic              stream_ready_i,
    output logic [DATA_W-1:0] stream_data_o,
    output logic [ADDR_W-1:0] stream_idx_o,
    output logic              stream_last_o
);

    localparam int unsigned       Entries = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    rcon_state_e       state_q, state_d;
    logic [DATA_W-1:0] mem_q [Entries];

    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0] init_val_q, init_val_d;
    logic [DATA_W-1:0] init_next;
    logic              init_done_q, init_done_d;

    logic [ADDR_W-1:0] s_idx_q, s_idx_d;
    logic [ADDR_W-1:0] s_idx_nxt;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              s_last_q, s_last_d;

    logic [DATA_W-1:0] out_q;
    logic              out_valid_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              host_addr_ok;

    assign host_addr_ok = 32'(addr_i) < DEPTH;
    assign s_idx_nxt    = s_idx_q + ADDR_W'(1);

    rcon_xtime #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_xtime (
        .v_i (init_val_q),
        .v_o (init_next)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_val_d  = init_val_q;
        init_done_d = init_done_q;
        s_idx_d     = s_idx_q;
        s_valid_d   = s_valid_q;
        s_data_d    = s_data_q;
        s_last_d    = s_last_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_i;
        mem_wdata   = in_i;

        unique case (state_q)
            StIdle: begin
                mem_we = wr_en_i && host_addr_ok;
                // Init wins over a same-cycle stream request.
                if (init_start_i) begin
                    state_d     = StInit;
                    init_cnt_d  = '0;
                    init_val_d  = SEED;
                    init_done_d = 1'b0;
                end else if (stream_start_i && init_done_q) begin
                    state_d   = StStream;
                    s_idx_d   = '0;
                    s_valid_d = 1'b0;
                end
            end
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = init_val_q;
                init_val_d = init_next;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LastIdx) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StStream: begin
                // First cycle in stream only fetches entry 0; afterwards each
                // handshake prefetches the next entry so transfers run back-to-back.
                if (!s_valid_q) begin
                    s_valid_d = 1'b1;
                    s_data_d  = mem_q[s_idx_q];
                    s_last_d  = (s_idx_q == LastIdx);
                end else if (stream_ready_i) begin
                    if (s_last_q) begin
                        s_valid_d = 1'b0;
                        s_last_d  = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        s_idx_d  = s_idx_nxt;
                        s_data_d = mem_q[s_idx_nxt];
                        s_last_d = (s_idx_nxt == LastIdx);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            init_cnt_q  <= '0;
            init_val_q  <= '0;
            init_done_q <= 1'b0;
            s_idx_q     <= '0;
            s_valid_q   <= 1'b0;
            s_data_q    <= '0;
            s_last_q    <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_val_q  <= init_val_d;
            init_done_q <= init_done_d;
            s_idx_q     <= s_idx_d;
            s_valid_q   <= s_valid_d;
            s_data_q    <= s_data_d;
            s_last_q    <= s_last_d;
            out_valid_q <= rd_en_i;
            if (rd_en_i) begin
                out_q <= host_addr_ok ? mem_q[addr_i] : '0;
            end
        end
    end

    // Storage has no reset; a reset edge still blocks any pending write.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign out_o          = out_q;
    assign out_valid_o    = out_valid_q;
    assign init_busy_o    = (state_q == StInit);
    assign init_done_o    = init_done_q;
    assign stream_valid_o = s_valid_q;
    assign stream_data_o  = s_data_q;
    assign stream_idx_o   = s_idx_q;
    assign stream_last_o  = s_last_q;

endmodule

// File: tb/tb_rcon_table_gen.sv
module tb_rcon_table_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic       rst, wr_en, rd_en, init_start, stream_start, stream_ready;
    logic [7:0] din;
    logic [3:0] addr;
    logic [7:0] dout, stream_data;
    logic [3:0] stream_idx;
    logic       out_valid, init_busy, init_done, stream_valid, stream_last;

    // Narrow DUT: DATA_W=4, DEPTH=6, POLY=3
    logic       p_wr_en, p_rd_en, p_init_start, p_stream_start, p_stream_ready;
    logic [3:0] p_din, p_dout, p_stream_data;
    logic [2:0] p_addr, p_stream_idx;
    logic       p_out_valid, p_init_busy, p_init_done, p_stream_valid, p_stream_last;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic [7:0] rd_q [$];
    logic [3:0] p_rd_q [$];
    beat_t      st_q [$];

    logic [7:0] golden   [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [3:0] p_golden [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};

    rcon_table_gen u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_i           (din),
        .wr_en_i        (wr_en),
        .rd_en_i        (rd_en),
        .addr_i         (addr),
        .out_o          (dout),
        .out_valid_o    (out_valid),
        .init_start_i   (init_start),
        .init_busy_o    (init_busy),
        .init_done_o    (init_done),
        .stream_start_i (stream_start),
        .stream_valid_o (stream_valid),
        .stream_ready_i (stream_ready),
        .stream_data_o  (stream_data),
        .stream_idx_o   (stream_idx),
        .stream_last_o  (stream_last)
    );

    rcon_table_gen #(
        .DATA_W (4),
        .DEPTH  (6),
        .ADDR_W (3),
        .POLY   (4'h3),
        .SEED   (4'h1)
    ) u_dut_narrow (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_i           (p_din),
        .wr_en_i        (p_wr_en),
        .rd_en_i        (p_rd_en),
        .addr_i         (p_addr),
        .out_o          (p_dout),
        .out_valid_o    (p_out_valid),
        .init_start_i   (p_init_start),
        .init_busy_o    (p_init_busy),
        .init_done_o    (p_init_done),
        .stream_start_i (p_stream_start),
        .stream_valid_o (p_stream_valid),
        .stream_ready_i (p_stream_ready),
        .stream_data_o  (p_stream_data),
        .stream_idx_o   (p_stream_idx),
        .stream_last_o  (p_stream_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the default DUT to finish a fill.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (init_done === 1'b1 && init_busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 0; rd_en = 0; init_start = 0; stream_start = 0; stream_ready = 0;
        din = '0; addr = '0;
        p_wr_en = 0; p_rd_en = 0; p_init_start = 0; p_stream_start = 0; p_stream_ready = 0;
        p_din = '0; p_addr = '0;
        tick();
        tick();
        checks++;
        if ({dout, out_valid, init_busy, init_done, stream_valid, stream_data, stream_idx,
             stream_last} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h ov=%b busy=%b done=%b sv=%b sd=%h si=%h sl=%b, want all 0",
                     dout, out_valid, init_busy, init_done, stream_valid, stream_data,
                     stream_idx, stream_last);
        end
        checks++;
        if ({p_dout, p_out_valid, p_init_busy, p_init_done, p_stream_valid, p_stream_data,
             p_stream_idx, p_stream_last} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs_narrow: got nonzero outputs, want all 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_autofill();
        logic [7:0] exp;
        logic       exp_busy;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        checks++;
        if (init_busy !== 1'b1 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL fill_edge0: got busy=%b done=%b, want busy=1 done=0", init_busy, init_done);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_busy = (e < 10);
            checks++;
            if (init_busy !== exp_busy || init_done !== !exp_busy) begin
                errors++;
                $display("FAIL fill_edge%0d: got busy=%b done=%b, want busy=%b done=%b",
                         e, init_busy, init_done, exp_busy, !exp_busy);
            end
        end
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1;
            addr  = 4'(i);
            rd_q.push_back(golden[i]);
            tick();
            exp = rd_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || dout !== exp) begin
                errors++;
                $display("FAIL fill_read[%0d]: got ov=%b out=%h, want ov=1 out=%h",
                         i, out_valid, dout, exp);
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || dout !== golden[9]) begin
            errors++;
            $display("FAIL read_hold: got ov=%b out=%h, want ov=0 out=%h", out_valid, dout, golden[9]);
        end
    endtask

    task automatic test_stream_backpressure();
        int         cyc = 0;
        int         got = 0;
        logic       stall;
        logic [12:0] held;
        beat_t      b;
        logic [7:0] exp;
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        checks++;
        if (stream_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_edge0: got valid=%b, want 0", stream_valid);
        end
        for (int i = 0; i < 10; i++) st_q.push_back({golden[i], 4'(i), (i == 9)});
        // Host write attempt while streaming must be dropped.
        wr_en = 1'b1; addr = 4'd0; din = 8'hFF;
        while (got < 10 && cyc < 60) begin
            stream_ready = (cyc % 2 == 0);
            if (stream_valid === 1'b1 && stream_ready) begin
                b = st_q.pop_front();
                got++;
                checks++;
                if ({stream_data, stream_idx, stream_last} !== b) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                             got, stream_data, stream_idx, stream_last, b.data, b.idx, b.last);
                end
            end
            stall = (stream_valid === 1'b1) && !stream_ready;
            held  = {stream_data, stream_idx, stream_last};
            tick();
            wr_en = 1'b0;
            if (stall) begin
                checks++;
                if ({stream_data, stream_idx, stream_last} !== held) begin
                    errors++;
                    $display("FAIL stream_stall: got %h, want held %h",
                             {stream_data, stream_idx, stream_last}, held);
                end
            end
            cyc++;
        end
        stream_ready = 1'b0;
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL stream_count: got %0d transfers, want 10", got);
        end
        checks++;
        if (stream_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got valid=%b, want 0", stream_valid);
        end
        rd_en = 1'b1; addr = 4'd0;
        rd_q.push_back(8'h01);
        tick();
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL stream_wr_ignored: got %h, want %h", dout, exp);
        end
    endtask

    task automatic test_write_gating();
        logic [7:0] exp;
        bit         ok;
        wr_en = 1'b1; addr = 4'd3; din = 8'hAA;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        rd_q.push_back(8'hAA);
        tick();
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL idle_write: got %h, want %h", dout, exp);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL done_after_write: got %b, want 1", init_done);
        end
        wr_en = 1'b1; addr = 4'd12; din = 8'h77;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        rd_q.push_back(8'h00);
        tick();
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (dout !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range: got ov=%b out=%h, want ov=1 out=%h", out_valid, dout, exp);
        end
        // Refill: entry 3 still holds AA when read at edge 1; host write at edge 2 dropped.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        rd_en = 1'b1; addr = 4'd3;
        rd_q.push_back(8'hAA);
        tick();
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL init_read_old: got %h, want %h", dout, exp);
        end
        wr_en = 1'b1; addr = 4'd0; din = 8'h55;
        tick();
        wr_en = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL refill_timeout: got done=%b, want 1", init_done);
        end
        for (int i = 0; i < 4; i += 3) begin
            rd_en = 1'b1; addr = 4'(i);
            rd_q.push_back(golden[i]);
            tick();
            exp = rd_q.pop_front();
            checks++;
            if (dout !== exp) begin
                errors++;
                $display("FAIL refill_read[%0d]: got %h, want %h", i, dout, exp);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        bit         ok;
        init_start = 1'b1; stream_start = 1'b1;
        tick();
        init_start = 1'b0; stream_start = 1'b0;
        checks++;
        if (init_busy !== 1'b1 || stream_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_priority: got busy=%b sv=%b, want busy=1 sv=0", init_busy, stream_valid);
        end
        wait_done(ok);
        tick();
        checks++;
        if (!ok || stream_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_priority_end: got done=%b sv=%b, want done=1 sv=0", init_done, stream_valid);
        end
        rd_en = 1'b1; wr_en = 1'b1; addr = 4'd5; din = 8'hC3;
        rd_q.push_back(golden[5]);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL rw_same_cycle: got %h, want %h", dout, exp);
        end
        rd_en = 1'b1;
        rd_q.push_back(8'hC3);
        tick();
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL rw_followup: got %h, want %h", dout, exp);
        end
    endtask

    task automatic test_back_to_back();
        bit    ok;
        beat_t b;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_fill_timeout: got done=%b, want 1", init_done);
        end
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        stream_ready = 1'b1;
        for (int i = 0; i < 10; i++) st_q.push_back({golden[i], 4'(i), (i == 9)});
        tick();
        for (int i = 0; i < 10; i++) begin
            b = st_q.pop_front();
            checks++;
            if (stream_valid !== 1'b1 || {stream_data, stream_idx, stream_last} !== b) begin
                errors++;
                $display("FAIL b2b_beat%0d: got v=%b data=%h idx=%0d last=%b, want v=1 data=%h idx=%0d last=%b",
                         i, stream_valid, stream_data, stream_idx, stream_last, b.data, b.idx, b.last);
            end
            tick();
        end
        stream_ready = 1'b0;
        checks++;
        if (stream_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b, want 0", stream_valid);
        end
    endtask

    task automatic test_reset_mid_init();
        bit ok;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({dout, out_valid, init_busy, init_done, stream_valid, stream_data, stream_idx,
             stream_last} !== 26'd0) begin
            errors++;
            $display("FAIL midinit_reset: got busy=%b done=%b sv=%b out=%h, want all 0",
                     init_busy, init_done, stream_valid, dout);
        end
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        tick();
        tick();
        checks++;
        if (stream_valid !== 1'b0 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_without_init: got sv=%b busy=%b, want 0 0", stream_valid, init_busy);
        end
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midinit_refill_timeout: got done=%b, want 1", init_done);
        end
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        tick();
        checks++;
        if (stream_valid !== 1'b1 || stream_data !== 8'h01 || stream_idx !== 4'd0) begin
            errors++;
            $display("FAIL stream_after_refill: got v=%b data=%h idx=%0d, want v=1 data=01 idx=0",
                     stream_valid, stream_data, stream_idx);
        end
        stream_ready = 1'b1;
        repeat (10) tick();
        stream_ready = 1'b0;
        checks++;
        if (stream_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_after_refill_end: got valid=%b, want 0", stream_valid);
        end
    endtask

    task automatic test_param();
        logic [3:0] exp;
        bit         ok;
        p_init_start = 1'b1;
        tick();
        p_init_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (p_init_done === 1'b1 && p_init_busy === 1'b0) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL narrow_fill_timeout: got done=%b, want 1", p_init_done);
        end
        for (int i = 0; i < 7; i++) begin
            p_rd_en = 1'b1;
            p_addr  = 3'(i);
            p_rd_q.push_back((i < 6) ? p_golden[i] : 4'h0);
            tick();
            exp = p_rd_q.pop_front();
            checks++;
            if (p_out_valid !== 1'b1 || p_dout !== exp) begin
                errors++;
                $display("FAIL narrow_read[%0d]: got ov=%b out=%h, want ov=1 out=%h",
                         i, p_out_valid, p_dout, exp);
            end
        end
        p_rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_autofill();
        test_stream_backpressure();
        test_write_gating();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_init();
        test_param();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1);
    end

endmodule
